// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC unit: FSM encoding, instruction size,
// reset PC default and the memory read/write encoding.
package fetch_pc_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_REQ      = 2'b01,
      ST_WAIT_MFC = 2'b10
   } fetch_state_e;

   localparam logic [31:0] INSTR_BYTES      = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // mem_rw encoding, shared with the data-memory interface
   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   // True when an address is a legal instruction (word) address
   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_npc_reg.sv
// PC/nPC register pair with next-nPC selection (JMPL target, branch target,
// sequential) and rejection of word-misaligned JMPL targets.
module pc_npc_reg
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        adv_en,
   input  logic        branch_taken,
   input  logic [31:0] disp,
   input  logic        jmpl_load,
   input  logic [31:0] jmpl_addr,
   output logic [31:0] pc,
   output logic [31:0] npc,
   output logic        adv_accept,
   output logic        misaligned
);

   logic [31:0] pc_r;
   logic [31:0] npc_r;
   logic [31:0] npc_next_s;
   logic        bad_target_s;
   logic        misaligned_r;

   // Next-nPC mux: JMPL target beats branch target beats sequential; adders wrap
   always_comb begin
      npc_next_s   = npc_r + INSTR_BYTES;
      bad_target_s = jmpl_load & ~is_word_aligned(jmpl_addr);
      if (jmpl_load) begin
         npc_next_s = jmpl_addr;
      end else if (branch_taken) begin
         npc_next_s = pc_r + disp;
      end else begin
         npc_next_s = npc_r + INSTR_BYTES;
      end
   end

   // A misaligned JMPL target suppresses the whole advance
   assign adv_accept = adv_en & ~bad_target_s;

   // PC/nPC update on an accepted advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r  <= RESET_PC;
         npc_r <= RESET_PC + INSTR_BYTES;
      end else if (adv_accept) begin
         pc_r  <= npc_r;
         npc_r <= npc_next_s;
      end else begin
         pc_r  <= pc_r;
         npc_r <= npc_r;
      end
   end

   // One-cycle pulse flagging a rejected JMPL target
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misaligned_r <= 1'b0;
      end else begin
         misaligned_r <= adv_en & bad_target_s;
      end
   end

   assign pc         = pc_r;
   assign npc        = npc_r;
   assign misaligned = misaligned_r;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/PC unit: holds PC/nPC and fetches the instruction at PC into ir via
// the MOV/MFC memory handshake. Optional macro FETCH_TIMEOUT_EN adds an MFC
// timeout that raises a sticky fetch_err; without it fetch_err is tied 0.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int          MFC_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_req,
   input  logic        advance,
   input  logic        branch_taken,
   input  logic [31:0] disp,
   input  logic        jmpl_load,
   input  logic [31:0] jmpl_addr,
   output logic [31:0] mem_addr,
   output logic        mem_mov,
   output logic        mem_rw,
   input  logic [31:0] mem_data,
   input  logic        mem_mfc,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic [31:0] pc,
   output logic [31:0] npc,
   output logic        fetch_busy,
   output logic        misaligned,
   output logic        fetch_err
);

   fetch_state_e state_r, state_next_s;
   logic [31:0]  mem_addr_r, mem_addr_next_s;
   logic         mem_mov_r, mem_mov_next_s;
   logic [31:0]  ir_r, ir_next_s;
   logic         ir_valid_r, ir_valid_next_s;
   logic         fetch_busy_r;
   logic         adv_accept_s;
   logic         timeout_s;

   pc_npc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_npc_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .adv_en       (advance & ~fetch_busy_r),
      .branch_taken (branch_taken),
      .disp         (disp),
      .jmpl_load    (jmpl_load),
      .jmpl_addr    (jmpl_addr),
      .pc           (pc),
      .npc          (npc),
      .adv_accept   (adv_accept_s),
      .misaligned   (misaligned)
   );

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);
   logic [CNT_W-1:0] mfc_cnt_r;
   logic             fetch_err_r;

   assign timeout_s = (state_r == ST_WAIT_MFC) && !mem_mfc &&
                      (mfc_cnt_r == CNT_W'(MFC_TIMEOUT - 1));

   // Count WAIT_MFC cycles without a completion; restart on every new request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mfc_cnt_r <= '0;
      end else if (state_r == ST_REQ) begin
         mfc_cnt_r <= '0;
      end else if ((state_r == ST_WAIT_MFC) && !mem_mfc) begin
         mfc_cnt_r <= mfc_cnt_r + CNT_W'(1);
      end else begin
         mfc_cnt_r <= mfc_cnt_r;
      end
   end

   // Sticky timeout flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_err_r <= 1'b0;
      end else begin
         fetch_err_r <= fetch_err_r | timeout_s;
      end
   end

   assign fetch_err = fetch_err_r;
`else
   assign timeout_s = 1'b0;
   assign fetch_err = 1'b0;
`endif

   // Fetch FSM next state and next values of the registered fetch outputs
   always_comb begin
      state_next_s    = state_r;
      mem_addr_next_s = mem_addr_r;
      mem_mov_next_s  = mem_mov_r;
      ir_next_s       = ir_r;
      ir_valid_next_s = ir_valid_r;
      case (state_r)
         ST_IDLE: begin
            if (fetch_req) begin
               state_next_s    = ST_REQ;
               ir_valid_next_s = 1'b0;
            end else if (adv_accept_s) begin
               ir_valid_next_s = 1'b0;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            mem_addr_next_s = pc;
            mem_mov_next_s  = 1'b1;
            state_next_s    = ST_WAIT_MFC;
         end
         ST_WAIT_MFC: begin
            if (mem_mfc) begin
               ir_next_s       = mem_data;
               ir_valid_next_s = 1'b1;
               mem_mov_next_s  = 1'b0;
               state_next_s    = ST_IDLE;
            end else if (timeout_s) begin
               mem_mov_next_s = 1'b0;
               state_next_s   = ST_IDLE;
            end else begin
               state_next_s = ST_WAIT_MFC;
            end
         end
         default: begin
            mem_mov_next_s = 1'b0;
            state_next_s   = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered fetch outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         mem_addr_r   <= 32'h0000_0000;
         mem_mov_r    <= 1'b0;
         ir_r         <= 32'h0000_0000;
         ir_valid_r   <= 1'b0;
         fetch_busy_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         mem_addr_r   <= mem_addr_next_s;
         mem_mov_r    <= mem_mov_next_s;
         ir_r         <= ir_next_s;
         ir_valid_r   <= ir_valid_next_s;
         fetch_busy_r <= (state_next_s != ST_IDLE);
      end
   end

   assign mem_addr   = mem_addr_r;
   assign mem_mov    = mem_mov_r;
   assign mem_rw     = MEM_READ;
   assign ir         = ir_r;
   assign ir_valid   = ir_valid_r;
   assign fetch_busy = fetch_busy_r;

endmodule
